// File: rtl/branch_redirect_unit.sv
// branch_redirect_unit
//   Consumer end of the RV32I branch comparison path. Takes the comparison
//   unit's 'approved' result and the EX-stage control-flow info, computes the
//   target and drives a valid/ready redirect to fetch. It also flushes the
//   younger stages, stalls EX while a redirect is pending, and raises a
//   one-cycle exception on a taken target that is not 4-byte aligned.
//
// Ports
//   clk, rst_n       clock (rising edge) / asynchronous active-low reset
//   ex_valid         EX holds a valid instruction
//   ex_branch        EX instruction is a conditional branch
//   ex_jal           EX instruction is JAL
//   ex_jalr          EX instruction is JALR
//   ex_pc            PC of the EX instruction
//   ex_imm           sign-extended immediate
//   ex_rs1           rs1 operand (JALR base)
//   approved         branch condition true
//   redir_ready      fetch accepts the redirect
//   redir_valid      redirect request pending
//   redir_pc         redirect target, stable while redir_valid is high
//   flush            kill IF/ID instructions
//   ex_stall         EX must hold (its inputs are ignored)
//   misalign_exc     one-cycle pulse: taken target is misaligned
//   misalign_addr    offending target, held until the next exception
//   branch_cnt       resolved conditional branches (saturating)
//   taken_cnt        taken redirects issued (saturating)
module branch_redirect_unit #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_jal,
  input  logic             ex_jalr,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic             approved,
  input  logic             redir_ready,
  output logic             redir_valid,
  output logic [XLEN-1:0]  redir_pc,
  output logic             flush,
  output logic             ex_stall,
  output logic             misalign_exc,
  output logic [XLEN-1:0]  misalign_addr,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  // The flush counter only ever holds FLUSH_CYCLES-1 down to 0.
  localparam int CW         = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int CNT_INIT_I = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;
  localparam logic [CW-1:0] CNT_INIT = CNT_INIT_I[CW-1:0];

  state_t          state;
  logic [CW-1:0]   cnt;

  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic            take;
  logic            count_branch;
  logic            aligned;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // JALR has top priority for target selection; bit 0 of its sum is cleared.
  assign jalr_sum     = ex_rs1 + ex_imm;
  assign target       = ex_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (ex_pc + ex_imm);
  assign aligned      = (target[1:0] == 2'b00);
  assign take         = ex_valid & (ex_jalr | ex_jal | (ex_branch & approved));
  // Only a pure conditional branch counts; jal/jalr override the branch bit.
  assign count_branch = ex_valid & ex_branch & ~ex_jal & ~ex_jalr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      redir_valid   <= 1'b0;
      redir_pc      <= '0;
      flush         <= 1'b0;
      ex_stall      <= 1'b0;
      misalign_exc  <= 1'b0;
      misalign_addr <= '0;
      branch_cnt    <= '0;
      taken_cnt     <= '0;
    end else begin
      misalign_exc <= 1'b0;
      case (state)
        IDLE: begin
          if (count_branch) branch_cnt <= sat_inc(branch_cnt);
          if (take) begin
            if (aligned) begin
              redir_pc    <= target;
              redir_valid <= 1'b1;
              flush       <= 1'b1;
              ex_stall    <= 1'b1;
              taken_cnt   <= sat_inc(taken_cnt);
              state       <= REDIRECT;
            end else begin
              misalign_exc  <= 1'b1;
              misalign_addr <= target;
            end
          end
        end
        REDIRECT: begin
          // Hold the request indefinitely until fetch accepts it.
          if (redir_ready) begin
            redir_valid <= 1'b0;
            ex_stall    <= 1'b0;
            if (FLUSH_CYCLES == 0) begin
              flush <= 1'b0;
              state <= IDLE;
            end else begin
              cnt   <= CNT_INIT;
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (cnt == '0) begin
            flush <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
